// File: rtl/pipe_trace_pkg.sv
// Shared opcode/funct codes, tracker state encoding and the pipe slot type
// used by the retire tracker and its destination decoder.
package pipe_trace_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b010011;
    localparam logic [5:0] OP_BEQ    = 6'b011001;
    localparam logic [5:0] OP_LW     = 6'b011000;
    localparam logic [5:0] OP_SW     = 6'b101000;

    localparam logic [5:0] FUNC_ADD  = 6'b100011;
    localparam logic [5:0] FUNC_SUB  = 6'b010011;
    localparam logic [5:0] FUNC_AND  = 6'b011111;
    localparam logic [5:0] FUNC_OR   = 6'b101111;
    localparam logic [5:0] FUNC_NOR  = 6'b010000;
    localparam logic [5:0] FUNC_SLT  = 6'b010100;
    localparam logic [5:0] FUNC_SLLV = 6'b011000;
    localparam logic [5:0] FUNC_SLL  = 6'b010010;
    localparam logic [5:0] FUNC_SRLV = 6'b101000;
    localparam logic [5:0] FUNC_SRL  = 6'b100010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
    } slot_t;

    function automatic logic is_known_funct(input logic [5:0] funct);
        case (funct)
            FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_NOR,
            FUNC_SLT, FUNC_SLLV, FUNC_SLL, FUNC_SRLV, FUNC_SRL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_dest_decode.sv
// Combinational decode of the register a retiring instruction should write:
// R-type with a known funct writes rd, addi/lw write rt, everything else writes nothing.
module instr_dest_decode
    import pipe_trace_pkg::*;
(
    input  logic [31:0] instr,
    output logic        exp_we,
    output logic [4:0]  dest
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        exp_we = 1'b0;
        dest   = 5'd0;
        case (opcode)
            OP_RTYPE: begin
                if (is_known_funct(funct)) begin
                    exp_we = 1'b1;
                    dest   = instr[15:11];
                end
            end
            OP_ADDI, OP_LW: begin
                exp_we = 1'b1;
                dest   = instr[20:16];
            end
            OP_SW, OP_BEQ: begin
                exp_we = 1'b0;
            end
            default: begin
                exp_we = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/pipe_retire_tracker.sv
// Shadow pipe that follows fetched instructions to writeback, pulses on retirement,
// cross-checks the DUT register-file write and reports end of program / timeout / fail.
//   state   | meaning
//   IDLE    | waiting for start_i, pipe empty
//   RUN     | tracking fetches until a zero word is fetched
//   DRAIN   | fetch forced to bubbles, pipe empties for DEPTH non-stalled cycles
//   DONE    | program finished cleanly (sticky)
//   TIMEOUT | cycle budget exhausted (sticky)
//   FAIL    | writeback mismatch with STOP_ON_ERR set (sticky)
module pipe_retire_tracker
    import pipe_trace_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int STALL_SLOT  = 2,
    parameter int FLUSH_SLOT  = 2,
    parameter int MAX_CYCLES  = 15,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             if_valid_i,
    input  logic [31:0]      if_instr_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_addr_i,
    output logic [2:0]       state_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             fail_o,
    output logic             retire_valid_o,
    output logic [31:0]      retire_instr_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [31:0]      first_err_instr_o
);
    localparam int               DRN_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(DEPTH);
    localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);

    state_t              state;
    slot_t [DEPTH-1:0]   slots;
    slot_t [DEPTH-1:0]   slots_nxt;
    slot_t               fetch;
    slot_t               ret_slot;
    logic [DRN_W-1:0]    drain_cnt;
    logic                active, stalled, retiring, exp_we, skip_chk;
    logic                mismatch, end_fetch, drain_last;
    logic [4:0]          dest;

    assign state_o    = state;
    assign active     = (state == ST_RUN) || (state == ST_DRAIN);
    assign stalled    = stall_i && !flush_i;
    assign ret_slot   = slots[DEPTH-1];
    assign retiring   = ret_slot.valid && (ret_slot.instr != 32'h0);
    assign skip_chk   = exp_we && (dest == 5'd0);
    // Outside a retirement any write is spurious; during one, compare against the decode.
    assign mismatch   = active && (retiring ?
                        (!skip_chk && ((wb_we_i != exp_we) || (wb_we_i && (wb_addr_i != dest))))
                        : wb_we_i);
    assign end_fetch  = (state == ST_RUN) && if_valid_i && (if_instr_i == 32'h0)
                        && !stall_i && !flush_i;
    assign drain_last = (state == ST_DRAIN) && !stalled && (drain_cnt == DRN_ONE);

    instr_dest_decode u_decode (
        .instr  (ret_slot.instr),
        .exp_we (exp_we),
        .dest   (dest)
    );

    always_comb begin
        fetch = '0;
        if (state == ST_RUN) begin
            fetch.valid = if_valid_i;
            fetch.instr = if_instr_i;
        end
    end

    always_comb begin
        slots_nxt = slots;
        if (flush_i)
            slots_nxt[0] = (FLUSH_SLOT > 0) ? slot_t'('0) : fetch;
        else if (stall_i)
            slots_nxt[0] = (STALL_SLOT > 0) ? slots[0] : slot_t'('0);
        else
            slots_nxt[0] = fetch;
        for (int k = 1; k < DEPTH; k++) begin
            if (flush_i)
                slots_nxt[k] = (k < FLUSH_SLOT) ? slot_t'('0) : slots[k-1];
            else if (stall_i)
                slots_nxt[k] = (k < STALL_SLOT) ? slots[k] :
                               (k == STALL_SLOT) ? slot_t'('0) : slots[k-1];
            else
                slots_nxt[k] = slots[k-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= ST_IDLE;
            slots             <= '0;
            drain_cnt         <= '0;
            done_o            <= 1'b0;
            timeout_o         <= 1'b0;
            fail_o            <= 1'b0;
            retire_valid_o    <= 1'b0;
            retire_instr_o    <= 32'h0;
            retire_cnt_o      <= '0;
            err_cnt_o         <= '0;
            cycle_cnt_o       <= '0;
            first_err_instr_o <= 32'h0;
        end else begin
            retire_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i)
                        state <= ST_RUN;
                end
                ST_RUN, ST_DRAIN: begin
                    slots <= slots_nxt;
                    if (cycle_cnt_o != '1)
                        cycle_cnt_o <= cycle_cnt_o + CNT_ONE;
                    if (retiring) begin
                        retire_valid_o <= 1'b1;
                        retire_instr_o <= ret_slot.instr;
                        if (retire_cnt_o != '1)
                            retire_cnt_o <= retire_cnt_o + CNT_ONE;
                    end
                    if (mismatch) begin
                        if (err_cnt_o == '0)
                            first_err_instr_o <= ret_slot.instr;
                        if (err_cnt_o != '1)
                            err_cnt_o <= err_cnt_o + CNT_ONE;
                    end
                    if (state == ST_DRAIN && !stalled)
                        drain_cnt <= drain_cnt - DRN_ONE;

                    if (mismatch && STOP_ON_ERR) begin
                        state  <= ST_FAIL;
                        fail_o <= 1'b1;
                    end else if (drain_last) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end else if (cycle_cnt_o == CYC_LAST) begin
                        state     <= ST_TIMEOUT;
                        timeout_o <= 1'b1;
                    end else if (end_fetch) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRN_INIT;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_retire_tracker.sv
// Directed bench for pipe_retire_tracker: one task per scenario with hand-computed expectations.
module tb_pipe_retire_tracker;
    import pipe_trace_pkg::*;

    localparam logic [31:0] ADDI1 = {6'b010011, 5'd0, 5'd1, 16'd5};
    localparam logic [31:0] ADD2  = {6'b000000, 5'd1, 5'd1, 5'd2, 5'd0, 6'b100011};
    localparam logic [31:0] LW4   = {6'b011000, 5'd0, 5'd4, 16'h0010};
    localparam logic [31:0] ADD5  = {6'b000000, 5'd4, 5'd4, 5'd5, 5'd0, 6'b100011};
    localparam logic [31:0] BEQ   = {6'b011001, 5'd1, 5'd2, 16'd2};
    localparam logic [31:0] ADDI6 = {6'b010011, 5'd0, 5'd6, 16'd1};
    localparam logic [31:0] ADDI7 = {6'b010011, 5'd0, 5'd7, 16'd1};
    localparam logic [31:0] ADDI8 = {6'b010011, 5'd0, 5'd8, 16'd1};
    localparam logic [31:0] SW1   = {6'b101000, 5'd0, 5'd1, 16'd4};

    logic        clk_i, rst_i, start_i, if_valid_i, stall_i, flush_i, wb_we_i;
    logic [31:0] if_instr_i;
    logic [4:0]  wb_addr_i;

    logic [2:0]  st_a, st_b;
    logic        done_a, to_a, fail_a, rv_a, done_b, to_b, fail_b, rv_b;
    logic [31:0] ri_a, fe_a, ri_b, fe_b;
    logic [15:0] rc_a, ec_a, cc_a, rc_b, ec_b, cc_b;

    int checks = 0;
    int failures = 0;

    pipe_retire_tracker u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .if_valid_i(if_valid_i),
        .if_instr_i(if_instr_i), .stall_i(stall_i), .flush_i(flush_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .state_o(st_a), .done_o(done_a), .timeout_o(to_a),
        .fail_o(fail_a), .retire_valid_o(rv_a), .retire_instr_o(ri_a), .retire_cnt_o(rc_a),
        .err_cnt_o(ec_a), .cycle_cnt_o(cc_a), .first_err_instr_o(fe_a)
    );

    pipe_retire_tracker #(.STOP_ON_ERR(1'b0)) u_dut_ne (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .if_valid_i(if_valid_i),
        .if_instr_i(if_instr_i), .stall_i(stall_i), .flush_i(flush_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .state_o(st_b), .done_o(done_b), .timeout_o(to_b),
        .fail_o(fail_b), .retire_valid_o(rv_b), .retire_instr_o(ri_b), .retire_cnt_o(rc_b),
        .err_cnt_o(ec_b), .cycle_cnt_o(cc_b), .first_err_instr_o(fe_b)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic cyc(input logic v, input logic [31:0] ins, input logic st,
                       input logic fl, input logic we, input logic [4:0] ad);
        if_valid_i = v; if_instr_i = ins; stall_i = st; flush_i = fl;
        wb_we_i = we; wb_addr_i = ad;
        @(posedge clk_i); #1;
        if_valid_i = 1'b0; if_instr_i = 32'h0; stall_i = 1'b0; flush_i = 1'b0;
        wb_we_i = 1'b0; wb_addr_i = 5'd0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; start_i = 1'b0;
        if_valid_i = 1'b0; if_instr_i = 32'h0; stall_i = 1'b0; flush_i = 1'b0;
        wb_we_i = 1'b0; wb_addr_i = 5'd0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic start_run();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (st_a !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", st_a); end
        checks++; if ({done_a, to_a, fail_a, rv_a} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {done_a, to_a, fail_a, rv_a}); end
        checks++; if ({rc_a, ec_a, cc_a} !== 48'h0) begin failures++; $display("FAIL reset_counters got=%h exp=0", {rc_a, ec_a, cc_a}); end
        checks++; if ({ri_a, fe_a} !== 64'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", {ri_a, fe_a}); end
        cyc(1'b1, ADDI1, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, ADD2, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if ({st_a, cc_a} !== {3'd0, 16'd0}) begin failures++; $display("FAIL idle_no_start got=%0d/%0d exp=0/0", st_a, cc_a); end
    endtask

    task automatic test_basic();
        do_reset(); start_run();
        checks++; if (st_a !== 3'd1) begin failures++; $display("FAIL start_run got=%0d exp=1", st_a); end
        cyc(1'b1, ADDI1, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, ADD2, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if (st_a !== 3'd2) begin failures++; $display("FAIL basic_drain got=%0d exp=2", st_a); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if (rv_a !== 1'b0) begin failures++; $display("FAIL basic_no_early_retire got=%b exp=0", rv_a); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1);
        checks++; if ({rv_a, ri_a} !== {1'b1, ADDI1}) begin failures++; $display("FAIL basic_retire1 got=%b/%h exp=1/%h", rv_a, ri_a, ADDI1); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2);
        checks++; if ({rv_a, ri_a} !== {1'b1, ADD2}) begin failures++; $display("FAIL basic_retire2 got=%b/%h exp=1/%h", rv_a, ri_a, ADD2); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if ({st_a, done_a, to_a, fail_a, rv_a} !== {3'd3, 4'b1000}) begin failures++; $display("FAIL basic_done got=%0d/%b exp=3/1000", st_a, {done_a, to_a, fail_a, rv_a}); end
        checks++; if ({rc_a, ec_a, cc_a} !== {16'd2, 16'd0, 16'd7}) begin failures++; $display("FAIL basic_counts got=%0d/%0d/%0d exp=2/0/7", rc_a, ec_a, cc_a); end
        start_run();
        checks++; if ({st_a, cc_a, ri_a} !== {3'd3, 16'd7, ADD2}) begin failures++; $display("FAIL basic_hold got=%0d/%0d/%h exp=3/7/%h", st_a, cc_a, ri_a, ADD2); end
    endtask

    task automatic test_stall();
        do_reset(); start_run();
        cyc(1'b1, LW4, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, ADD5, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, ADD5, 1'b1, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if (st_a !== 3'd2) begin failures++; $display("FAIL stall_drain got=%0d exp=2", st_a); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if (rv_a !== 1'b0) begin failures++; $display("FAIL stall_delay got=%b exp=0", rv_a); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4);
        checks++; if ({rv_a, ri_a} !== {1'b1, LW4}) begin failures++; $display("FAIL stall_retire_lw got=%b/%h exp=1/%h", rv_a, ri_a, LW4); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5);
        checks++; if ({rv_a, ri_a} !== {1'b1, ADD5}) begin failures++; $display("FAIL stall_retire_add got=%b/%h exp=1/%h", rv_a, ri_a, ADD5); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if ({st_a, rc_a, ec_a, cc_a} !== {3'd3, 16'd2, 16'd0, 16'd8}) begin failures++; $display("FAIL stall_done got=%0d/%0d/%0d/%0d exp=3/2/0/8", st_a, rc_a, ec_a, cc_a); end
    endtask

    task automatic test_flush();
        do_reset(); start_run();
        cyc(1'b1, BEQ, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, ADDI6, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, ADDI7, 1'b0, 1'b1, 1'b0, 5'd0);
        cyc(1'b1, ADDI8, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if ({rv_a, ri_a} !== {1'b1, BEQ}) begin failures++; $display("FAIL flush_retire_beq got=%b/%h exp=1/%h", rv_a, ri_a, BEQ); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if (rv_a !== 1'b0) begin failures++; $display("FAIL flush_killed1 got=%b exp=0", rv_a); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if (rv_a !== 1'b0) begin failures++; $display("FAIL flush_killed2 got=%b exp=0", rv_a); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8);
        checks++; if ({rv_a, ri_a} !== {1'b1, ADDI8}) begin failures++; $display("FAIL flush_retire_tgt got=%b/%h exp=1/%h", rv_a, ri_a, ADDI8); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if ({st_a, rc_a, ec_a} !== {3'd3, 16'd2, 16'd0}) begin failures++; $display("FAIL flush_done got=%0d/%0d/%0d exp=3/2/0", st_a, rc_a, ec_a); end
    endtask

    task automatic test_mismatch_stop();
        do_reset(); start_run();
        cyc(1'b1, ADD2, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if (fail_a !== 1'b0) begin failures++; $display("FAIL stop_pre got=%b exp=0", fail_a); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3);
        checks++; if ({st_a, fail_a, done_a, to_a} !== {3'd5, 3'b100}) begin failures++; $display("FAIL stop_fail got=%0d/%b exp=5/100", st_a, {fail_a, done_a, to_a}); end
        checks++; if ({fe_a, ec_a, rc_a} !== {ADD2, 16'd1, 16'd1}) begin failures++; $display("FAIL stop_first_err got=%h/%0d/%0d exp=%h/1/1", fe_a, ec_a, rc_a, ADD2); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9);
        checks++; if ({st_a, ec_a} !== {3'd5, 16'd1}) begin failures++; $display("FAIL stop_hold got=%0d/%0d exp=5/1", st_a, ec_a); end
    endtask

    task automatic test_mismatch_continue();
        do_reset(); start_run();
        cyc(1'b1, ADD2, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3);
        checks++; if ({st_b, fail_b, ec_b} !== {3'd2, 1'b0, 16'd1}) begin failures++; $display("FAIL cont_first got=%0d/%b/%0d exp=2/0/1", st_b, fail_b, ec_b); end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if ({st_b, done_b, fail_b, to_b} !== {3'd3, 3'b100}) begin failures++; $display("FAIL cont_done got=%0d/%b exp=3/100", st_b, {done_b, fail_b, to_b}); end
        checks++; if ({ec_b, rc_b, fe_b} !== {16'd2, 16'd1, ADD2}) begin failures++; $display("FAIL cont_counts got=%0d/%0d/%h exp=2/1/%h", ec_b, rc_b, fe_b, ADD2); end
    endtask

    task automatic test_timeout();
        do_reset(); start_run();
        for (int i = 0; i < 14; i++) cyc(1'b1, SW1, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if ({st_a, to_a, cc_a} !== {3'd1, 1'b0, 16'd14}) begin failures++; $display("FAIL to_pre got=%0d/%b/%0d exp=1/0/14", st_a, to_a, cc_a); end
        cyc(1'b1, SW1, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if ({st_a, to_a, done_a, fail_a, cc_a} !== {3'd4, 3'b100, 16'd15}) begin failures++; $display("FAIL to_hit got=%0d/%b/%0d exp=4/100/15", st_a, {to_a, done_a, fail_a}, cc_a); end
        checks++; if ({rc_a, ec_a} !== {16'd11, 16'd0}) begin failures++; $display("FAIL to_counts got=%0d/%0d exp=11/0", rc_a, ec_a); end
        cyc(1'b1, SW1, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if ({st_a, cc_a} !== {3'd4, 16'd15}) begin failures++; $display("FAIL to_hold got=%0d/%0d exp=4/15", st_a, cc_a); end
        do_reset(); start_run();
        for (int i = 0; i < 6; i++) cyc(1'b1, SW1, 1'b0, 1'b0, 1'b0, 5'd0);
        checks++; if ({rv_a, rc_a, cc_a} !== {1'b1, 16'd2, 16'd6}) begin failures++; $display("FAIL midrst_pre got=%b/%0d/%0d exp=1/2/6", rv_a, rc_a, cc_a); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if ({st_a, rv_a, rc_a, cc_a, ri_a} !== {3'd0, 1'b0, 16'd0, 16'd0, 32'h0}) begin failures++; $display("FAIL midrst_async got=%0d/%b/%0d/%0d/%h exp=0/0/0/0/0", st_a, rv_a, rc_a, cc_a, ri_a); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_mismatch_stop();
        test_mismatch_continue();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
